mem_port_arbiter: RTL and testbench

Shares one single-ported synchronous SRAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the five-stage pipeline. It grants at most one access per cycle: data accesses have priority, and a starvation counter guarantees fetch progress. It routes the one-cycle-late read data back to the owning requester. It tracks in-flight reads so that a pipeline `cancel` discards a stale fetch response.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported synchronous SRAM between the
//             instruction-fetch requester (IF) and the data requester (MEM).
//             At most one access is granted per cycle. MEM has priority, but
//             a starvation counter forces an IF grant after STARVE_MAX
//             consecutive denied fetch cycles. Read data returns one cycle
//             after the grant and is routed to the requester that owns it.
//             A pipeline cancel discards the fetch response in flight.
//  Ports    : clk, reset            - clock, async active-high reset
//             if_req/if_addr        - fetch request (read only)
//             if_gnt                - fetch accepted this cycle
//             if_rvalid/if_rdata    - fetch response (rdata held between)
//             cancel                - kills any in-flight fetch response
//             mem_req/mem_wen/mem_addr/mem_wdata - data request
//             mem_gnt               - data accepted this cycle
//             mem_rvalid/mem_rdata  - load response (rdata held between)
//             sram_en/sram_wen/sram_addr/sram_wdata/sram_rdata - SRAM port
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_MAX = 3   // legal range 1..7 (3-bit counter)
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        cancel,

    input  logic        mem_req,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [2:0] C_STARVE_MAX = 3'(STARVE_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic        if_pend_q,    if_pend_d;
    logic        mem_pend_q,   mem_pend_d;
    logic [31:0] if_hold_q,    if_hold_d;
    logic [31:0] mem_hold_q,   mem_hold_d;

    logic        force_if;

    // ------------------------------------------------------------------
    // Grant arbitration (zero-latency, purely combinational)
    // ------------------------------------------------------------------
    always_comb begin
        force_if = if_req && (starve_cnt_q == C_STARVE_MAX);
        mem_gnt  = mem_req && !force_if;
        // IF only wins when MEM did not take the port, so the two grants
        // are mutually exclusive by construction.
        if_gnt   = if_req && !mem_gnt;
    end

    // ------------------------------------------------------------------
    // SRAM request mux; idle cycles drive every field to zero
    // ------------------------------------------------------------------
    always_comb begin
        sram_en    = if_gnt | mem_gnt;
        sram_wen   = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (mem_gnt) begin
            sram_wen   = mem_wen;
            sram_addr  = mem_addr;
            sram_wdata = mem_wdata;
        end else if (if_gnt) begin
            sram_addr  = if_addr;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles IF waited, resets as
    // soon as IF is served or stops asking.
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 3'd0;
        end else if (starve_cnt_q != C_STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // In-flight tracking and response routing
    // ------------------------------------------------------------------
    always_comb begin
        // A cancel in the grant cycle still lets the SRAM read proceed but
        // drops the response before it is ever marked pending.
        if_pend_d  = if_gnt && !cancel;
        // Writes complete at grant; only reads await data.
        mem_pend_d = mem_gnt && (mem_wen == 4'b0000);

        // A cancel in the response cycle suppresses the stale fetch data.
        if_rvalid  = if_pend_q && !cancel;
        mem_rvalid = mem_pend_q;

        if_rdata   = if_rvalid  ? sram_rdata : if_hold_q;
        mem_rdata  = mem_rvalid ? sram_rdata : mem_hold_q;

        // Holding registers keep each requester's last data stable until
        // its next response, independent of what the SRAM bus carries.
        if_hold_d  = if_rvalid  ? sram_rdata : if_hold_q;
        mem_hold_d = mem_rvalid ? sram_rdata : mem_hold_q;
    end

    // ------------------------------------------------------------------
    // Registers (asynchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 3'd0;
            if_pend_q    <= 1'b0;
            mem_pend_q   <= 1'b0;
            if_hold_q    <= 32'h0;
            mem_hold_q   <= 32'h0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_pend_q    <= if_pend_d;
            mem_pend_q   <= mem_pend_d;
            if_hold_q    <= if_hold_d;
            mem_hold_q   <= mem_hold_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. A behavioural SRAM
//             answers the DUT's port; expected read responses are queued
//             when a grant is driven and compared when their cycle comes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        cancel;
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    mem_port_arbiter #(.STARVE_MAX(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .cancel     (cancel),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural SRAM: unwritten words return an address-derived pattern
    // ------------------------------------------------------------------
    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] wtmp;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    always @(posedge clk) begin
        if (sram_en && sram_wen == 4'b0000) begin
            sram_rdata <= rd(sram_addr);
        end else begin
            // Garbage on idle cycles exposes any response not held properly.
            sram_rdata <= $urandom;
            if (sram_en) begin
                wtmp = rd(sram_addr);
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) wtmp[8*b +: 8] = sram_wdata[8*b +: 8];
                sram_mem[sram_addr] = wtmp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } resp_t;

    resp_t       if_q[$];
    resp_t       mem_q[$];
    logic [31:0] if_hold;
    logic [31:0] mem_hold;
    int          cyc;
    int          n_vec;
    int          n_bad;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check responses due now, check grants
    // and the SRAM mux, then queue responses for reads granted this cycle.
    task automatic step(input logic        rst_v,
                        input logic        ifr,
                        input logic [31:0] ia,
                        input logic        mr,
                        input logic [3:0]  wen,
                        input logic [31:0] ma,
                        input logic [31:0] wd,
                        input logic        cn,
                        input logic        eig,
                        input logic        emg);
        resp_t e;
        logic  exp_ifv;
        logic  exp_mv;
        @(negedge clk);
        reset     = rst_v;
        if_req    = ifr;
        if_addr   = ia;
        mem_req   = mr;
        mem_wen   = wen;
        mem_addr  = ma;
        mem_wdata = wd;
        cancel    = cn;
        #1;
        if (rst_v) begin
            if_q.delete();
            mem_q.delete();
            if_hold  = 32'h0;
            mem_hold = 32'h0;
        end
        exp_ifv = 1'b0;
        if (if_q.size() > 0 && if_q[0].cyc == cyc) begin
            e = if_q.pop_front();
            if (!cn) begin
                exp_ifv = 1'b1;
                if_hold = e.data;
            end
        end
        exp_mv = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
            e = mem_q.pop_front();
            exp_mv   = 1'b1;
            mem_hold = e.data;
        end
        check_eq("if_rvalid",  32'(if_rvalid),  32'(exp_ifv));
        check_eq("if_rdata",   if_rdata,        if_hold);
        check_eq("mem_rvalid", 32'(mem_rvalid), 32'(exp_mv));
        check_eq("mem_rdata",  mem_rdata,       mem_hold);
        check_eq("if_gnt",     32'(if_gnt),     32'(eig));
        check_eq("mem_gnt",    32'(mem_gnt),    32'(emg));
        check_eq("sram_en",    32'(sram_en),    32'(eig | emg));
        check_eq("sram_wen",   32'(sram_wen),   emg ? 32'(wen) : 32'h0);
        check_eq("sram_addr",  sram_addr,       emg ? ma : (eig ? ia : 32'h0));
        check_eq("sram_wdata", sram_wdata,      emg ? wd : 32'h0);
        if (!rst_v) begin
            if (eig && !cn)
                if_q.push_back('{cyc: cyc + 1, data: rd(ia)});
            if (emg && wen == 4'b0000)
                mem_q.push_back('{cyc: cyc + 1, data: rd(ma)});
        end
        cyc++;
    endtask

    task automatic idle(input logic rst_v);
        step(rst_v, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] a, input logic cn);
        step(1'b0, 1'b1, a, 1'b0, 4'h0, 32'h0, 32'h0, cn, 1'b1, 1'b0);
    endtask

    // Both requesters asking; MEM reads mem_a, IF fetches if_a.
    task automatic both(input logic [31:0] if_a, input logic [31:0] mem_a,
                        input logic eig, input logic emg);
        step(1'b0, 1'b1, if_a, 1'b1, 4'h0, mem_a, 32'h0, 1'b0, eig, emg);
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        if_hold = 32'h0; mem_hold = 32'h0;
        reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; cancel = 1'b0;
        mem_req = 1'b0; mem_wen = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        sram_rdata = 32'h0;
        sram_mem[32'h100] = 32'h2402_0001;

        // Reset: all outputs quiet; a request during reset is granted but
        // never answered.
        idle(1'b1);
        idle(1'b1);
        step(1'b1, 1'b1, 32'h500, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Lone fetch, then hold the data across idle cycles.
        fetch(32'h100, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        // Conflict: MEM wins three times, IF is forced, MEM wins again.
        both(32'h104, 32'h200, 1'b0, 1'b1);
        both(32'h104, 32'h200, 1'b0, 1'b1);
        both(32'h104, 32'h200, 1'b0, 1'b1);
        both(32'h104, 32'h200, 1'b1, 1'b0);
        both(32'h108, 32'h204, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // Store: byte enables and data reach the SRAM, no response; then
        // load the merged word back.
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // Cancel in the response cycle, then cancel in the grant cycle.
        fetch(32'h10C, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        fetch(32'h110, 1'b1);
        idle(1'b0);
        // Cancel does not touch MEM reads.
        step(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0,   32'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);

        // Back-to-back fetches give back-to-back responses.
        fetch(32'h114, 1'b0);
        fetch(32'h118, 1'b0);
        fetch(32'h11C, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Reset mid-read with the starvation counter part way up.
        fetch(32'h100, 1'b0);
        both(32'h120, 32'h208, 1'b0, 1'b1);
        both(32'h120, 32'h20C, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Counter must restart from 0: three MEM wins before IF is forced.
        both(32'h124, 32'h210, 1'b0, 1'b1);
        both(32'h124, 32'h210, 1'b0, 1'b1);
        both(32'h124, 32'h210, 1'b0, 1'b1);
        both(32'h124, 32'h210, 1'b1, 1'b0);
        idle(1'b0);

        // Lone fetch again after reset.
        fetch(32'h100, 1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
